// File: rtl/acs_if.sv
// Branch-metric input and ACS result bundle between the BMU, the ACS stage and the survivor memory.
interface acs_if #(
    parameter int PM_W  = 6,
    parameter int CNT_W = 8
);
    logic             start;
    logic             in_valid;
    logic [1:0]       bmc00_path_0;
    logic [1:0]       bmc00_path_1;
    logic [1:0]       bmc01_path_0;
    logic [1:0]       bmc01_path_1;
    logic [1:0]       bmc10_path_0;
    logic [1:0]       bmc10_path_1;
    logic [1:0]       bmc11_path_0;
    logic [1:0]       bmc11_path_1;
    logic             out_valid;
    logic [3:0]       dec;
    logic [PM_W-1:0]  pm0;
    logic [PM_W-1:0]  pm1;
    logic [PM_W-1:0]  pm2;
    logic [PM_W-1:0]  pm3;
    logic             norm_evt;
    logic [CNT_W-1:0] sym_cnt;
    logic             frame_done;
    logic [1:0]       best_state;

    modport master (
        output start, in_valid,
        output bmc00_path_0, bmc00_path_1, bmc01_path_0, bmc01_path_1,
        output bmc10_path_0, bmc10_path_1, bmc11_path_0, bmc11_path_1,
        input  out_valid, dec, pm0, pm1, pm2, pm3, norm_evt, sym_cnt, frame_done, best_state
    );

    modport slave (
        input  start, in_valid,
        input  bmc00_path_0, bmc00_path_1, bmc01_path_0, bmc01_path_1,
        input  bmc10_path_0, bmc10_path_1, bmc11_path_0, bmc11_path_1,
        output out_valid, dec, pm0, pm1, pm2, pm3, norm_evt, sym_cnt, frame_done, best_state
    );
endinterface

// File: rtl/acs_unit.sv
// Add-compare-select stage of a rate-1/2 K=3 Viterbi decoder with path-metric normalisation.
// Optional argmin output of the path metrics is built when ACS_BEST_STATE_EN is defined.
module acs_unit #(
    parameter int PM_W      = 6,
    parameter int INIT_PM   = 16,
    parameter int FRAME_LEN = 16,
    parameter int CNT_W     = 8
) (
    input logic  clk,
    input logic  rst_n,
    acs_if.slave bus
);
    localparam logic [0:0]       IDLE = 1'b0;
    localparam logic [0:0]       RUN  = 1'b1;
    localparam logic [PM_W-1:0]  INIT = PM_W'(INIT_PM);
    localparam logic [PM_W:0]    HALF = (PM_W+1)'(2 ** (PM_W - 1));
    localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);

    logic [0:0]       state;
    logic [PM_W-1:0]  pm_q [4];
    logic [1:0]       bm [4][2];
    logic             accept;
    logic [PM_W-1:0]  src [4];
    logic [PM_W:0]    c0 [4];
    logic [PM_W:0]    c1 [4];
    logic [PM_W:0]    new_raw [4];
    logic [PM_W-1:0]  new_pm [4];
    logic [3:0]       dec_d;
    logic             norm_d;
    logic [CNT_W-1:0] cnt_d;
    logic             done_d;
    logic             out_valid_q;
    logic [3:0]       dec_q;
    logic             norm_q;
    logic [CNT_W-1:0] cnt_q;
    logic             done_q;

    assign bm[0][0] = bus.bmc00_path_0;
    assign bm[0][1] = bus.bmc00_path_1;
    assign bm[1][0] = bus.bmc01_path_0;
    assign bm[1][1] = bus.bmc01_path_1;
    assign bm[2][0] = bus.bmc10_path_0;
    assign bm[2][1] = bus.bmc10_path_1;
    assign bm[3][0] = bus.bmc11_path_0;
    assign bm[3][1] = bus.bmc11_path_1;

    // Symbols arriving in IDLE without start are dropped entirely.
    assign accept = bus.in_valid && (bus.start || state == RUN);

    always_comb begin
        dec_d  = '0;
        norm_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src[i] = bus.start ? ((i == 0) ? '0 : INIT) : pm_q[i];
        end
        // Next state n has predecessors {0,n[1]} and {1,n[1]} driven by input bit n[0].
        for (int n = 0; n < 4; n++) begin
            c0[n]      = {1'b0, src[n / 2]}     + (PM_W+1)'(bm[n / 2][n % 2]);
            c1[n]      = {1'b0, src[2 + n / 2]} + (PM_W+1)'(bm[2 + n / 2][n % 2]);
            dec_d[n]   = (c1[n] < c0[n]);
            new_raw[n] = dec_d[n] ? c1[n] : c0[n];
            if (new_raw[n] < HALF) begin
                norm_d = 1'b0;
            end
        end
        for (int n = 0; n < 4; n++) begin
            new_pm[n] = norm_d ? PM_W'(new_raw[n] - HALF) : PM_W'(new_raw[n]);
        end
        cnt_d  = bus.start ? CNT_W'(1) : cnt_q + CNT_W'(1);
        done_d = (cnt_d == LEN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            dec_q       <= '0;
            norm_q      <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            pm_q[0]     <= '0;
            pm_q[1]     <= INIT;
            pm_q[2]     <= INIT;
            pm_q[3]     <= INIT;
        end else begin
            out_valid_q <= accept;
            done_q      <= accept && done_d;
            if (accept) begin
                for (int n = 0; n < 4; n++) begin
                    pm_q[n] <= new_pm[n];
                end
                dec_q  <= dec_d;
                norm_q <= norm_d;
                cnt_q  <= cnt_d;
                state  <= done_d ? IDLE : RUN;
            end
        end
    end

`ifdef ACS_BEST_STATE_EN
    logic [1:0]      best_d;
    logic [PM_W-1:0] best_pm;
    logic [1:0]      best_q;

    // Strict compare in ascending order keeps the lowest index on ties.
    always_comb begin
        best_d  = 2'd0;
        best_pm = new_pm[0];
        for (int i = 1; i < 4; i++) begin
            if (new_pm[i] < best_pm) begin
                best_d  = 2'(i);
                best_pm = new_pm[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= 2'd0;
        end else if (accept) begin
            best_q <= best_d;
        end
    end

    assign bus.best_state = best_q;
`else
    assign bus.best_state = 2'b00;
`endif

    assign bus.out_valid  = out_valid_q;
    assign bus.dec        = dec_q;
    assign bus.pm0        = pm_q[0];
    assign bus.pm1        = pm_q[1];
    assign bus.pm2        = pm_q[2];
    assign bus.pm3        = pm_q[3];
    assign bus.norm_evt   = norm_q;
    assign bus.sym_cnt    = cnt_q;
    assign bus.frame_done = done_q;
endmodule
